// File: rtl/dqpsk_pkg.sv
// Shared DQPSK link definitions: checker state encoding, PRBS-7 taps and symbol width.
package dqpsk_pkg;

    localparam int SYM_W    = 2;
    localparam int PRBS_LEN = 7;

    // x^7 + x^6 + 1: the newest bit is s[6]^s[5] of the previous 7-bit history
    localparam int PRBS_TAP_A = 6;
    localparam int PRBS_TAP_B = 5;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_LOCK = 2'd1
    } state_t;

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {v[1] & v[0], v[1] ^ v[0]};
    endfunction

endpackage

// File: rtl/prbs7_step2.sv
// Two-bit-per-step PRBS-7 predictor: from history s gives the next symbol and the advanced state.
module prbs7_step2
    import dqpsk_pkg::*;
(
    input  logic [PRBS_LEN-1:0] s,
    output logic [SYM_W-1:0]    pred,
    output logic [PRBS_LEN-1:0] s_next
);

    // pred[1] is the earlier bit in time, matching the demodulator's bit order
    assign pred   = {s[PRBS_TAP_A] ^ s[PRBS_TAP_B], s[PRBS_TAP_A-1] ^ s[PRBS_TAP_B-1]};
    assign s_next = {s[PRBS_LEN-SYM_W-1:0], pred};

endmodule

// File: rtl/prbs_ber_checker.sv
// Self-synchronising PRBS-7 bit-error-rate checker for the DQPSK demodulator symbol stream.
module prbs_ber_checker
    import dqpsk_pkg::*;
#(
    parameter int LOCK_CNT   = 16,
    parameter int WINDOW     = 64,
    parameter int UNLOCK_ERR = 8,
    parameter int CNT_W      = 32
) (
    input  logic             clk_dds,
    input  logic             rst,
    input  logic             syn_in,
    input  logic [SYM_W-1:0] data_in,
    input  logic             clear,
    output logic             locked,
    output logic             sym_valid,
    output logic [SYM_W-1:0] sym_err,
    output logic [CNT_W-1:0] bit_num,
    output logic [CNT_W-1:0] bit_err_num
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = $clog2(WINDOW + 1);
    localparam int WERR_W  = $clog2(UNLOCK_ERR + SYM_W + 1);

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // stage p0..p2: syn_in synchroniser and falling-edge detect
    logic syn_p0, syn_p1, syn_p2;
    logic fall;

    always_ff @(posedge clk_dds or posedge rst) begin
        if (rst) begin
            syn_p0 <= 1'b0;
            syn_p1 <= 1'b0;
            syn_p2 <= 1'b0;
        end else begin
            syn_p0 <= syn_in;
            syn_p1 <= syn_p0;
            syn_p2 <= syn_p1;
        end
    end

    assign fall = syn_p2 & ~syn_p1;

    // capture stage: symbol register with its valid
    logic             vld_p0;
    logic [SYM_W-1:0] d_p0;

    always_ff @(posedge clk_dds or posedge rst) begin
        if (rst) vld_p0 <= 1'b0;
        else     vld_p0 <= fall;
    end

    always_ff @(posedge clk_dds) begin
        if (fall) d_p0 <= data_in;
    end

    // check stage: prediction, FSM, window and saturating counters
    state_t              state, state_nxt;
    logic [PRBS_LEN-1:0] s, s_nxt, s_free, s_load;
    logic [SYM_W-1:0]    pred, e, sym_err_nxt;
    logic [1:0]          e_cnt;
    logic [MATCH_W-1:0]  match_cnt, match_nxt;
    logic [WIN_W-1:0]    win_sym, win_sym_nxt, win_sym_inc;
    logic [WERR_W-1:0]   win_err, win_err_nxt, win_err_inc;
    logic                unlock_p, unlock_nxt;
    logic [CNT_W-1:0]    bit_num_nxt, bit_err_nxt;

    prbs7_step2 u_step (
        .s      (s),
        .pred   (pred),
        .s_next (s_free)
    );

    assign e           = d_p0 ^ pred;
    assign e_cnt       = popcount2(e);
    assign s_load      = {s[PRBS_LEN-SYM_W-1:0], d_p0};
    assign win_sym_inc = win_sym + 1'b1;
    assign win_err_inc = win_err + WERR_W'(e_cnt);

    always_comb begin
        state_nxt   = state;
        s_nxt       = s;
        match_nxt   = match_cnt;
        win_sym_nxt = win_sym;
        win_err_nxt = win_err;
        unlock_nxt  = 1'b0;
        bit_num_nxt = bit_num;
        bit_err_nxt = bit_err_num;
        sym_err_nxt = sym_err;

        if (unlock_p) begin
            state_nxt   = ST_HUNT;
            win_sym_nxt = '0;
            win_err_nxt = '0;
        end else if (vld_p0) begin
            case (state)
                ST_LOCK: begin
                    s_nxt       = s_free;
                    sym_err_nxt = e;
                    if (!clear) begin
                        bit_num_nxt = sat_add(bit_num, 2'd2);
                        bit_err_nxt = sat_add(bit_err_num, e_cnt);
                        // an unlocking error at the window boundary takes priority over the wrap
                        if (win_err_inc >= WERR_W'(UNLOCK_ERR)) begin
                            unlock_nxt  = 1'b1;
                            win_sym_nxt = win_sym_inc;
                            win_err_nxt = win_err_inc;
                        end else if (win_sym_inc == WIN_W'(WINDOW)) begin
                            win_sym_nxt = '0;
                            win_err_nxt = '0;
                        end else begin
                            win_sym_nxt = win_sym_inc;
                            win_err_nxt = win_err_inc;
                        end
                    end
                end
                default: begin
                    state_nxt   = ST_HUNT;
                    s_nxt       = s_load;
                    sym_err_nxt = '0;
                    // an all-zero history is the PRBS lock-up state and must never count as a match
                    if (e == '0 && s_load != '0) begin
                        if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                            state_nxt   = ST_LOCK;
                            match_nxt   = '0;
                            win_sym_nxt = '0;
                            win_err_nxt = '0;
                        end else begin
                            match_nxt = match_cnt + 1'b1;
                        end
                    end else begin
                        match_nxt = '0;
                    end
                end
            endcase
        end

        if (clear) begin
            bit_num_nxt = '0;
            bit_err_nxt = '0;
            win_sym_nxt = '0;
            win_err_nxt = '0;
        end
    end

    always_ff @(posedge clk_dds or posedge rst) begin
        if (rst) begin
            state       <= ST_HUNT;
            s           <= '0;
            match_cnt   <= '0;
            win_sym     <= '0;
            win_err     <= '0;
            unlock_p    <= 1'b0;
            sym_valid   <= 1'b0;
            sym_err     <= '0;
            bit_num     <= '0;
            bit_err_num <= '0;
        end else begin
            state       <= state_nxt;
            s           <= s_nxt;
            match_cnt   <= match_nxt;
            win_sym     <= win_sym_nxt;
            win_err     <= win_err_nxt;
            unlock_p    <= unlock_nxt;
            sym_valid   <= vld_p0;
            sym_err     <= sym_err_nxt;
            bit_num     <= bit_num_nxt;
            bit_err_num <= bit_err_nxt;
        end
    end

    assign locked = (state == ST_LOCK);

endmodule

// File: tb/tb_prbs_ber_checker.sv
// Bench for prbs_ber_checker: vector table driven through a per-symbol scoreboard, plus reset corner cases.
module tb_prbs_ber_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       syn_in = 1'b1;
    logic [1:0] data_in = 2'b00;
    logic       clear = 1'b0;

    logic        locked, sym_valid;
    logic [1:0]  sym_err;
    logic [31:0] bit_num, bit_err_num;

    logic        locked4, sym_valid4;
    logic [1:0]  sym_err4;
    logic [3:0]  bit_num4, bit_err_num4;

    always #5 clk = ~clk;

    prbs_ber_checker dut (
        .clk_dds     (clk),
        .rst         (rst),
        .syn_in      (syn_in),
        .data_in     (data_in),
        .clear       (clear),
        .locked      (locked),
        .sym_valid   (sym_valid),
        .sym_err     (sym_err),
        .bit_num     (bit_num),
        .bit_err_num (bit_err_num)
    );

    prbs_ber_checker #(.CNT_W(4)) dut4 (
        .clk_dds     (clk),
        .rst         (rst),
        .syn_in      (syn_in),
        .data_in     (data_in),
        .clear       (clear),
        .locked      (locked4),
        .sym_valid   (sym_valid4),
        .sym_err     (sym_err4),
        .bit_num     (bit_num4),
        .bit_err_num (bit_err_num4)
    );

    typedef struct {
        int         idx;
        logic [1:0] d;
        bit         clr_cap;
        bit         pre_clr;
        bit         exp_lk;
        logic [1:0] exp_err;
        int         exp_bn;
        int         exp_ben;
        int         exp_bn4;
        bit         exp_lk_after;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    vec_t vecs[$];
    vec_t zvecs[$];
    vec_t sb[$];
    bit   prbs[0:599];
    int   gi = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int min15(input int x);
        return (x > 15) ? 15 : x;
    endfunction

    function automatic logic [1:0] gen_sym();
        logic [1:0] r;
        r  = {prbs[2*gi], prbs[2*gi+1]};
        gi = gi + 1;
        return r;
    endfunction

    task automatic add_vec(input logic [1:0] d, input bit clr_cap, input bit pre_clr, input bit lk,
                           input logic [1:0] err, input int bn, input int ben, input int bn4, input bit lk_after);
        vec_t v;
        v.idx = vecs.size();
        v.d = d; v.clr_cap = clr_cap; v.pre_clr = pre_clr; v.exp_lk = lk; v.exp_err = err;
        v.exp_bn = bn; v.exp_ben = ben; v.exp_bn4 = bn4; v.exp_lk_after = lk_after;
        vecs.push_back(v);
    endtask

    // syn_in falls at a negedge; sym_valid appears on the 4th posedge, locked is sampled after the 5th
    task automatic send_sym(input logic [1:0] d, input bit clr_cap, output logic lk_after);
        @(negedge clk);
        data_in = d;
        syn_in  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (clr_cap) clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(posedge clk);
        #1;
        lk_after = locked;
        syn_in = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic apply(input vec_t v);
        logic lk;
        if (v.pre_clr) begin
            @(negedge clk);
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
            #1;
            chk($sformatf("clear_pulse_bn[%0d]", v.idx), bit_num, 0);
            chk($sformatf("clear_pulse_ben[%0d]", v.idx), bit_err_num, 0);
        end
        sb.push_back(v);
        send_sym(v.d, v.clr_cap, lk);
        chk($sformatf("locked_after[%0d]", v.idx), 32'(lk), 32'(v.exp_lk_after));
    endtask

    initial begin
        int nerr;
        bit flip;
        logic [1:0] d;

        // PRBS-7 seeded with all ones: b[n] = b[n-7] ^ b[n-6]
        for (int n = 0; n < 600; n++) prbs[n] = (n < 7) ? 1'b1 : (prbs[n-7] ^ prbs[n-6]);

        // Symbols 1-3 cannot be predicted from an empty history; matching starts at symbol 4,
        // so the 16th consecutive match (and the lock) is symbol 19.
        for (int k = 1; k <= 19; k++)
            add_vec(gen_sym(), 0, 0, (k == 19), 2'b00, 0, 0, 0, (k == 19));
        for (int i = 1; i <= 100; i++)
            add_vec(gen_sym(), 0, 0, 1, 2'b00, 2*i, 0, min15(2*i), 1);
        add_vec(gen_sym(), 1, 0, 1, 2'b00, 0, 0, 0, 1);
        nerr = 0;
        for (int j = 0; j < 60; j++) begin
            flip = (j % 10 == 9);
            d    = gen_sym() ^ {1'b0, flip};
            if (flip) nerr++;
            add_vec(d, 0, 0, 1, flip ? 2'b01 : 2'b00, 2*(j+1), nerr, min15(2*(j+1)), 1);
        end
        for (int k = 1; k <= 4; k++)
            add_vec(~gen_sym(), 0, (k == 1), 1, 2'b11, 2*k, 2*k, 2*k, (k < 4));
        for (int k = 1; k <= 16; k++)
            add_vec(gen_sym(), 0, 0, (k == 16), 2'b00, 8, 8, 8, (k == 16));
        for (int k = 0; k < 50; k++) begin
            vec_t z;
            z.idx = 1000 + k; z.d = 2'b00; z.clr_cap = 0; z.pre_clr = 0; z.exp_lk = 0;
            z.exp_err = 2'b00; z.exp_bn = 0; z.exp_ben = 0; z.exp_bn4 = 0; z.exp_lk_after = 0;
            zvecs.push_back(z);
        end

        fork
            forever begin
                @(negedge clk);
                if (sym_valid || sym_valid4) begin
                    if (sb.size() == 0) begin
                        chk("valid_without_symbol", 32'(sym_valid), 0);
                    end else begin
                        vec_t r;
                        r = sb.pop_front();
                        chk($sformatf("valid4[%0d]", r.idx), 32'(sym_valid4), 32'(sym_valid));
                        chk($sformatf("locked[%0d]", r.idx), 32'(locked), 32'(r.exp_lk));
                        chk($sformatf("sym_err[%0d]", r.idx), 32'(sym_err), 32'(r.exp_err));
                        chk($sformatf("bit_num[%0d]", r.idx), bit_num, r.exp_bn);
                        chk($sformatf("bit_err_num[%0d]", r.idx), bit_err_num, r.exp_ben);
                        chk($sformatf("bit_num4[%0d]", r.idx), 32'(bit_num4), r.exp_bn4);
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        chk("reset_locked", 32'(locked), 0);
        chk("reset_valid", 32'(sym_valid), 0);
        chk("reset_sym_err", 32'(sym_err), 0);
        chk("reset_bit_num", bit_num, 0);
        chk("reset_bit_err_num", bit_err_num, 0);
        chk("reset_locked4", 32'(locked4), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // asynchronous reset part-way through a symbol while locked
        @(negedge clk);
        data_in = 2'b10;
        syn_in  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_locked", 32'(locked), 0);
        chk("midrst_valid", 32'(sym_valid), 0);
        chk("midrst_sym_err", 32'(sym_err), 0);
        chk("midrst_bit_num", bit_num, 0);
        chk("midrst_bit_err_num", bit_err_num, 0);
        chk("midrst_bit_num4", 32'(bit_num4), 0);
        chk("midrst_bit_err_num4", 32'(bit_err_num4), 0);
        chk("midrst_sym_err4", 32'(sym_err4), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        syn_in = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("postrst_locked", 32'(locked), 0);
        chk("postrst_bit_num", bit_num, 0);

        for (int i = 0; i < zvecs.size(); i++) apply(zvecs[i]);

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
